// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-read-port register file.
// Optional build macro used by the register file: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register: never written, always reads as 0.
  localparam int ZERO_REG = 0;

  typedef logic [DATA_W_DEF-1:0] word_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode, zero/range masking,
// optional write-through bypass and the ren-gated output register.
// Macro REGFILE_BYPASS_EN: when defined, a same-edge write to the read
// address is forwarded to rdata.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ren,
  input  logic [ADDR_W-1:0]       raddr,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DEPTH*DATA_W-1:0] mem_flat,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] sel_val;
  logic              byp_hit;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Register 0 is never stored, so its slice of the bus is not looked at.
  logic unused_zero_slice;
  assign unused_zero_slice = ^mem_flat[ZERO_REG*DATA_W +: DATA_W];

  // Decode the read address; address 0 and out-of-range addresses match
  // no entry and therefore read as zero.
  always_comb begin
    sel_val = '0;
    for (int k = ZERO_REG + 1; k < DEPTH; k++) begin
      if (32'(raddr) == k) begin
        sel_val = mem_flat[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward a same-edge write only when it targets a real register.
  always_comb begin
    byp_hit = we && (raddr == waddr) &&
              (32'(waddr) != ZERO_REG) && (32'(waddr) < DEPTH);
  end
`else
  // Without bypass a same-edge collision returns the stored (old) value.
  logic unused_wr;
  assign unused_wr = ^{we, waddr, wdata};
  always_comb begin
    byp_hit = 1'b0;
  end
`endif

  // Capture on enabled cycles, hold the previous value on stall.
  always_comb begin
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = byp_hit ? wdata : sel_val;
    end
  end

  // Output register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mrp.sv
// Multi-read-port register file for the pipelined MIPS datapath.
// Owns storage and the WB write port; NUM_RD registered read ports.
// Macro REGFILE_BYPASS_EN enables write-to-read forwarding in each port.
module regfile_mrp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        ren,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata
);

  logic [DATA_W-1:0]       mem_d [DEPTH];
  logic [DATA_W-1:0]       mem_q [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;

  // Write decode: register 0 stays zero, out-of-range writes hit nothing.
  always_comb begin
    mem_d[ZERO_REG] = '0;
    for (int k = ZERO_REG + 1; k < DEPTH; k++) begin
      mem_d[k] = (we && (32'(waddr) == k)) ? wdata : mem_q[k];
    end
  end

  // Storage array, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_flat
      assign mem_flat[gi*DATA_W +: DATA_W] = mem_q[gi];
    end

    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_rd_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .ren      (ren[gi]),
        .raddr    (raddr[gi*ADDR_W +: ADDR_W]),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .mem_flat (mem_flat),
        .rdata    (rdata[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mrp.sv
// Self-checking bench for regfile_mrp (DEPTH=16, NUM_RD=3) with a
// behavioural model; follows REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mrp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEP = 16;
  localparam int NRD = 3;

  logic              clk;
  logic              rst_n;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NRD-1:0]    ren;
  logic [NRD*AW-1:0] raddr;
  logic [NRD*DW-1:0] rdata;

  int vectors;
  int miscompares;
  bit chk_en;

  // behavioural model state
  logic [DW-1:0] m_mem [DEP];
  logic [DW-1:0] m_rd  [NRD];

  regfile_mrp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .NUM_RD(NRD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rd(int p);
    return rdata[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] m_sel(logic [AW-1:0] a);
    if (int'(a) == 0 || int'(a) >= DEP) return '0;
    return m_mem[int'(a)];
  endfunction

  task automatic m_clear();
    for (int k = 0; k < DEP; k++) m_mem[k] = '0;
    for (int p = 0; p < NRD; p++) m_rd[p] = '0;
  endtask

  task automatic chk(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison of every port against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < NRD; p++) begin
        vectors++;
        if (rd(p) !== m_rd[p]) begin
          miscompares++;
          $display("FAIL model_port%0d: got %h expected %h at %0t", p, rd(p), m_rd[p], $time);
        end
      end
    end
  end

  // One clock cycle: drive at negedge, update model at posedge, return at negedge.
  task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [NRD-1:0] re, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [AW-1:0] a [NRD];
    bit wvalid;
    a[0] = a0; a[1] = a1; a[2] = a2;
    we = w; waddr = wa; wdata = wd; ren = re;
    raddr = {a2, a1, a0};
    @(posedge clk);
    wvalid = w && int'(wa) != 0 && int'(wa) < DEP;
    for (int p = 0; p < NRD; p++) begin
      if (re[p]) begin
`ifdef REGFILE_BYPASS_EN
        if (wvalid && a[p] == wa) m_rd[p] = wd;
        else m_rd[p] = m_sel(a[p]);
`else
        m_rd[p] = m_sel(a[p]);
`endif
      end
    end
    if (wvalid) m_mem[int'(wa)] = wd;
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    cycle(1'b1, wa, wd, 3'b000, 5'd0, 5'd0, 5'd0);
  endtask

  // Asynchronous reset asserted mid-cycle while a write and reads are pending.
  task automatic do_reset();
    we = 1'b1; waddr = 5'd5; wdata = 32'hBAD0_BAD0; ren = '1; raddr = {5'd5, 5'd5, 5'd5};
    #2 rst_n = 1'b0;
    m_clear();
    #1;
    for (int p = 0; p < NRD; p++) chk("rst_async", rd(p), 32'h0);
    @(negedge clk);
    for (int p = 0; p < NRD; p++) chk("rst_held", rd(p), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; chk_en = 1'b0;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ren = '0; raddr = '0;
    m_clear();
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < NRD; p++) chk("reset_state", rd(p), 32'h0);

    // Reset clearing
    wr(5'd5, 32'hDEADBEEF);
    cycle(1'b0, 5'd0, 32'h0, 3'b001, 5'd5, 5'd0, 5'd0);
    chk("r5_written", rd(0), 32'hDEADBEEF);
    do_reset();
    cycle(1'b0, 5'd0, 32'h0, 3'b001, 5'd5, 5'd0, 5'd0);
    chk("r5_after_reset", rd(0), 32'h0);

    // Sequential sweep
    for (int k = 1; k <= 10; k++) wr(5'(k), 32'(k));
    for (int k = 0; k <= 10; k++) begin
      cycle(1'b0, 5'd0, 32'h0, 3'b001, 5'(k), 5'd0, 5'd0);
      chk("sweep", rd(0), 32'(k));
    end

    // Register 0 and out-of-range
    wr(5'd0, 32'h12345678);
    cycle(1'b0, 5'd0, 32'h0, 3'b111, 5'd0, 5'd0, 5'd0);
    for (int p = 0; p < NRD; p++) chk("r0_zero", rd(p), 32'h0);
    wr(5'd20, 32'hCAFEF00D);
    cycle(1'b0, 5'd0, 32'h0, 3'b111, 5'd20, 5'd20, 5'd4);
    chk("oor_p0", rd(0), 32'h0);
    chk("oor_p1", rd(1), 32'h0);
    chk("oor_p2_r4", rd(2), 32'h4);

    // Stall hold on port 1
    wr(5'd3, 32'h33);
    wr(5'd4, 32'h44);
    cycle(1'b0, 5'd0, 32'h0, 3'b010, 5'd0, 5'd3, 5'd0);
    chk("stall_setup", rd(1), 32'h33);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 5'd0, 32'h0, 3'b000, 5'd0, 5'd4, 5'd0);
      chk("stall_hold", rd(1), 32'h33);
    end
    cycle(1'b0, 5'd0, 32'h0, 3'b010, 5'd0, 5'd4, 5'd0);
    chk("stall_release", rd(1), 32'h44);

    // Same-edge collision on port 0
    wr(5'd7, 32'h70);
    cycle(1'b1, 5'd7, 32'h77, 3'b001, 5'd7, 5'd0, 5'd0);
`ifdef REGFILE_BYPASS_EN
    chk("collision", rd(0), 32'h77);
`else
    chk("collision", rd(0), 32'h70);
`endif
    cycle(1'b0, 5'd0, 32'h0, 3'b001, 5'd7, 5'd0, 5'd0);
    chk("collision_next", rd(0), 32'h77);

    // Multi-port concurrency with an unrelated write
    cycle(1'b1, 5'd9, 32'h99, 3'b111, 5'd1, 5'd1, 5'd2);
    chk("multi_port", rdata, {32'h2, 32'h1, 32'h1});
    cycle(1'b0, 5'd0, 32'h0, 3'b111, 5'd9, 5'd9, 5'd9);
    chk("r9_written", rdata, {32'h99, 32'h99, 32'h99});

    // Randomised traffic, with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      cycle(1'($urandom), 5'($urandom_range(0, 31)), $urandom, 3'($urandom),
            5'($urandom_range(0, 20)), 5'($urandom_range(0, 20)), 5'($urandom_range(0, 20)));
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
